// File: rtl/multicast_hub.sv
`default_nettype none
// ============================================================================
//  Module      : multicast_hub
//  Description : NUM_CH operand FIFOs that fire together as one operand set
//                into a per-beat subset of NUM_COL PE columns.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicast_hub #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 3,
    parameter int NUM_COL    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             flush,
    input  logic [NUM_CH-1:0]                ch_en,
    input  logic [NUM_CH-1:0]                in_valid,
    output logic [NUM_CH-1:0]                in_ready,
    input  logic [NUM_CH*2*DATA_WIDTH-1:0]   in_data,
    input  logic [NUM_CH*NUM_COL-1:0]        in_mask,
    input  logic [NUM_COL-1:0]               pe_ready,
    output logic [NUM_COL-1:0]               pe_en,
    output logic [NUM_CH*2*DATA_WIDTH-1:0]   pe_data,
    output logic [NUM_CH-1:0]                fifo_empty,
    output logic [NUM_CH-1:0]                fifo_full,
    output logic                             busy,
    output logic                             err
);

    localparam int c_CH_W  = 2 * DATA_WIDTH;
    localparam int c_ENT_W = NUM_COL + c_CH_W;
    localparam int c_AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_AW-1:0] c_PTR_ONE = 1;
    localparam logic [c_AW:0]   c_CNT_ONE = 1;
    localparam logic [c_AW:0]   c_CNT_FULL = (c_AW+1)'(FIFO_DEPTH);

    logic [NUM_COL-1:0]         w_head_mask [NUM_CH];
    logic [c_CH_W-1:0]          w_head_data [NUM_CH];
    logic [NUM_CH-1:0]          w_empty;
    logic [NUM_CH-1:0]          w_full;
    logic                       w_all;
    logic                       w_fire;
    logic                       w_drop;
    logic                       w_pop_en;
    logic [NUM_COL-1:0]         w_target;
    logic [NUM_CH*c_CH_W-1:0]   w_set;

    logic [NUM_COL-1:0]         r_pe_en;
    logic [NUM_CH*c_CH_W-1:0]   r_pe_data;
    logic                       r_err;

    assign w_pop_en = w_fire | w_drop;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            logic [c_ENT_W-1:0] r_mem [FIFO_DEPTH];
            logic [c_AW-1:0]    r_wptr;
            logic [c_AW-1:0]    r_rptr;
            logic [c_AW:0]      r_cnt;
            logic               w_push;
            logic               w_pop;

            // Beats arriving during flush are accepted on the bus but discarded.
            assign w_push = in_valid[c] & in_ready[c] & ~flush;
            assign w_pop  = w_pop_en & ch_en[c] & ~flush;

            always_ff @(posedge clk) begin
                if (w_push)
                    r_mem[r_wptr] <= {in_mask[c*NUM_COL +: NUM_COL], in_data[c*c_CH_W +: c_CH_W]};
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                    r_cnt  <= '0;
                end else if (flush) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                    r_cnt  <= '0;
                end else begin
                    if (w_push)
                        r_wptr <= r_wptr + c_PTR_ONE;
                    if (w_pop)
                        r_rptr <= r_rptr + c_PTR_ONE;
                    case ({w_push, w_pop})
                        2'b10:   r_cnt <= r_cnt + c_CNT_ONE;
                        2'b01:   r_cnt <= r_cnt - c_CNT_ONE;
                        default: r_cnt <= r_cnt;
                    endcase
                end
            end

            assign w_empty[c]     = (r_cnt == '0);
            assign w_full[c]      = (r_cnt == c_CNT_FULL);
            assign in_ready[c]    = rstn & ~w_full[c];
            assign w_head_mask[c] = r_mem[r_rptr][c_ENT_W-1 -: NUM_COL];
            assign w_head_data[c] = r_mem[r_rptr][c_CH_W-1:0];
        end
    endgenerate

    always_comb begin
        w_all    = |ch_en;
        w_target = '1;
        w_set    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_en[c]) begin
                if (w_empty[c])
                    w_all = 1'b0;
                w_target = w_target & w_head_mask[c];
                w_set[c*c_CH_W +: c_CH_W] = w_head_data[c];
            end
        end
        // Only targeted columns must be ready; the rest are ignored.
        w_fire = w_all & (|w_target) & ~(|(w_target & ~pe_ready));
        w_drop = w_all & ~(|w_target);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pe_en   <= '0;
            r_pe_data <= '0;
            r_err     <= 1'b0;
        end else if (flush) begin
            r_pe_en   <= '0;
            r_pe_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_pe_en <= w_fire ? w_target : '0;
            if (w_fire)
                r_pe_data <= w_set;
            if (w_drop)
                r_err <= 1'b1;
        end
    end

    assign pe_en      = r_pe_en;
    assign pe_data    = r_pe_data;
    assign err        = r_err;
    assign fifo_empty = w_empty;
    assign fifo_full  = w_full;
    assign busy       = ~(&w_empty) | (|r_pe_en);

endmodule
`default_nettype wire

// File: tb/tb_multicast_hub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicast_hub
//  Description : Directed self-checking bench for multicast_hub (default params).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicast_hub;

    logic         clk;
    logic         rstn;
    logic         flush;
    logic [2:0]   ch_en;
    logic [2:0]   in_valid;
    logic [2:0]   in_ready;
    logic [95:0]  in_data;
    logic [11:0]  in_mask;
    logic [3:0]   pe_ready;
    logic [3:0]   pe_en;
    logic [95:0]  pe_data;
    logic [2:0]   fifo_empty;
    logic [2:0]   fifo_full;
    logic         busy;
    logic         err;

    int errors = 0;
    int checks = 0;

    multicast_hub #(
        .DATA_WIDTH (16),
        .NUM_CH     (3),
        .NUM_COL    (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .ch_en      (ch_en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mask    (in_mask),
        .pe_ready   (pe_ready),
        .pe_en      (pe_en),
        .pe_data    (pe_data),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] m0, input logic [3:0] m1, input logic [3:0] m2,
                        input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [2:0] v);
        in_mask  = {m2, m1, m0};
        in_data  = {d2, d1, d0};
        in_valid = v;
        tick();
        in_valid = 3'b000;
    endtask

    initial begin
        rstn     = 1'b0;
        flush    = 1'b0;
        ch_en    = 3'b111;
        in_valid = 3'b000;
        in_data  = '0;
        in_mask  = '0;
        pe_ready = 4'hF;
        tick();
        tick();

        // Reset state
        chk("rst_in_ready",   128'(in_ready),   128'(3'b000));
        chk("rst_fifo_empty", 128'(fifo_empty), 128'(3'b111));
        chk("rst_fifo_full",  128'(fifo_full),  128'(3'b000));
        chk("rst_busy",       128'(busy),       128'(1'b0));
        chk("rst_pe_en",      128'(pe_en),      128'(4'h0));
        chk("rst_pe_data",    128'(pe_data),    128'(96'h0));
        chk("rst_err",        128'(err),        128'(1'b0));
        rstn = 1'b1;
        #1;
        chk("post_rst_in_ready", 128'(in_ready), 128'(3'b111));

        // 1: broadcast to all columns, two edges after acceptance
        push(4'hF, 4'hF, 4'hF, 32'h0000_0011, 32'h0000_0022, 32'h0033_0033, 3'b111);
        chk("t1_pe_en_lat1", 128'(pe_en), 128'(4'h0));
        chk("t1_busy",       128'(busy),  128'(1'b1));
        tick();
        chk("t1_pe_en",   128'(pe_en),   128'(4'hF));
        chk("t1_pe_data", 128'(pe_data), 128'(96'h00330033_00000022_00000011));
        tick();
        chk("t1_pe_en_off", 128'(pe_en), 128'(4'h0));
        chk("t1_pe_data_hold", 128'(pe_data), 128'(96'h00330033_00000022_00000011));

        // 2: intersection of head masks
        push(4'b1110, 4'b0111, 4'b1111, 32'hA1, 32'hB1, 32'hC1, 3'b111);
        tick();
        chk("t2_pe_en",   128'(pe_en),   128'(4'b0110));
        chk("t2_pe_data", 128'(pe_data), 128'(96'h000000C1_000000B1_000000A1));
        tick();

        // 3: stall on a targeted column, then release
        pe_ready = 4'b1011;
        push(4'b1110, 4'b0111, 4'b1111, 32'hA2, 32'hB2, 32'hC2, 3'b111);
        tick();
        tick();
        chk("t3_stall_pe_en", 128'(pe_en),      128'(4'h0));
        chk("t3_stall_empty", 128'(fifo_empty), 128'(3'b000));
        pe_ready = 4'hF;
        tick();
        chk("t3_release_pe_en",   128'(pe_en),   128'(4'b0110));
        chk("t3_release_pe_data", 128'(pe_data), 128'(96'h000000C2_000000B2_000000A2));
        chk("t3_release_empty",   128'(fifo_empty), 128'(3'b111));
        pe_ready = 4'h0;
        in_mask  = 12'hFFF;
        for (int i = 0; i < 4; i++) begin
            in_data  = {32'h300 + 32'(i), 32'h200 + 32'(i), 32'h100 + 32'(i)};
            in_valid = 3'b111;
            tick();
        end
        in_valid = 3'b000;
        chk("t3_fifo_full", 128'(fifo_full), 128'(3'b111));
        chk("t3_in_ready",  128'(in_ready),  128'(3'b000));
        chk("t3_full_pe_en", 128'(pe_en),    128'(4'h0));
        pe_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_drain_pe_en",   128'(pe_en),   128'(4'hF));
            chk("t3_drain_pe_data", 128'(pe_data),
                128'({32'h300 + 32'(i), 32'h200 + 32'(i), 32'h100 + 32'(i)}));
        end
        tick();
        chk("t3_drained_empty", 128'(fifo_empty), 128'(3'b111));
        chk("t3_drained_busy",  128'(busy),       128'(1'b0));

        // 4: empty target drops the set and sets sticky err
        push(4'b0001, 4'b0010, 4'b1111, 32'hD0, 32'hD1, 32'hD2, 3'b111);
        tick();
        chk("t4_drop_pe_en", 128'(pe_en),      128'(4'h0));
        chk("t4_drop_err",   128'(err),        128'(1'b1));
        chk("t4_drop_empty", 128'(fifo_empty), 128'(3'b111));
        tick();
        chk("t4_err_sticky", 128'(err), 128'(1'b1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_flush_err", 128'(err), 128'(1'b0));

        // flush discards beats presented in the same cycle
        flush = 1'b1;
        push(4'hF, 4'hF, 4'hF, 32'hE0, 32'hE1, 32'hE2, 3'b111);
        flush = 1'b0;
        chk("flush_discard_empty", 128'(fifo_empty), 128'(3'b111));
        tick();
        chk("flush_discard_pe_en", 128'(pe_en), 128'(4'h0));

        // 5: ch2 disabled, its slot carries zero and its FIFO is untouched
        ch_en = 3'b011;
        push(4'hF, 4'hF, 4'h0, 32'h55, 32'h66, 32'h77, 3'b011);
        tick();
        chk("t5_pe_en",   128'(pe_en),      128'(4'hF));
        chk("t5_pe_data", 128'(pe_data),    128'(96'h00000000_00000066_00000055));
        chk("t5_empty",   128'(fifo_empty), 128'(3'b111));
        push(4'hF, 4'hF, 4'hF, 32'h0, 32'h0, 32'h99, 3'b100);
        tick();
        chk("t5_ch2_kept", 128'(fifo_empty), 128'(3'b011));
        chk("t5_no_fire",  128'(pe_en),      128'(4'h0));
        ch_en = 3'b000;
        push(4'hF, 4'hF, 4'hF, 32'h1, 32'h2, 32'h3, 3'b011);
        tick();
        chk("t5_chen0_no_pop", 128'(fifo_empty), 128'(3'b000));
        chk("t5_chen0_pe_en",  128'(pe_en),      128'(4'h0));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        ch_en = 3'b111;

        // 6: back-to-back stream, one fire per cycle
        pe_ready = 4'hF;
        in_mask  = 12'hFFF;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                in_data  = {32'h3000 + 32'(i), 32'h2000 + 32'(i), 32'h1000 + 32'(i)};
                in_valid = 3'b111;
            end else begin
                in_valid = 3'b000;
            end
            tick();
            if (i >= 1) begin
                chk("t6_stream_pe_en", 128'(pe_en), 128'(4'hF));
                chk("t6_stream_pe_data", 128'(pe_data),
                    128'({32'h3000 + 32'(i-1), 32'h2000 + 32'(i-1), 32'h1000 + 32'(i-1)}));
            end
        end
        tick();
        chk("t6_stream_end", 128'(pe_en), 128'(4'h0));

        // 6b: asynchronous reset in mid-stream
        for (int i = 0; i < 3; i++) begin
            in_data  = {32'h5000 + 32'(i), 32'h4000 + 32'(i), 32'h3000 + 32'(i)};
            in_valid = 3'b111;
            tick();
        end
        chk("t6_pre_rst_pe_en", 128'(pe_en), 128'(4'hF));
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_rst_pe_en",    128'(pe_en),      128'(4'h0));
        chk("t6_rst_empty",    128'(fifo_empty), 128'(3'b111));
        chk("t6_rst_in_ready", 128'(in_ready),   128'(3'b000));
        chk("t6_rst_busy",     128'(busy),       128'(1'b0));
        in_valid = 3'b000;
        tick();
        rstn = 1'b1;
        tick();
        tick();
        chk("t6_after_rst_pe_en", 128'(pe_en),      128'(4'h0));
        chk("t6_after_rst_empty", 128'(fifo_empty), 128'(3'b111));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
